// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//   Builds RV32I machine words from field-level requests and writes them, one
//   after another, into instruction memory starting at BASE_ADDR. It is the
//   encode-side mirror of the control decoder. The program loader and self-test
//   path use it to fill imem while the pipeline is still held in reset.
//   Illegal requests are still handshaked. They write nothing and raise err.
//
// Handshakes
//   Request side:  a transfer happens on a rising edge where req_valid && req_ready.
//                  req_valid may be held or dropped freely.
//   Memory side:   a write completes on a rising edge where im_wr_en && im_ready.
//                  im_wr_en, im_addr and im_wdata stay stable until that edge.
//
// Ports
//   clk, rst        clock (rising edge), synchronous active-high reset
//   clear           synchronous restart of address/count; drops a pending write
//   req_valid/ready request handshake
//   req_cls         0 R,1 I,2 LOAD,3 STORE,4 BRANCH,5 AUIPC,6 LUI,7 JAL,8 JALR
//   req_alu_op      R/I operation; req_br_type branch kind; req_mem_f3 load/store width
//   req_rd/rs1/rs2  register indices; req_imm full (unshifted) immediate
//   im_wr_en/addr/wdata/ready  imem write port
//   err, err_code   one-cycle error pulse; code 1 class, 2 op/funct, 3 immediate
//   count, full     words written since reset/clear, count==DEPTH
//   dbg_state       FSM state: 0 IDLE, 1 WRITE, 2 FULL
// -----------------------------------------------------------------------------
module instr_encoder #(
    parameter int unsigned DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [3:0]                   req_cls,
    input  logic [3:0]                   req_alu_op,
    input  logic [2:0]                   req_br_type,
    input  logic [2:0]                   req_mem_f3,
    input  logic [4:0]                   req_rd,
    input  logic [4:0]                   req_rs1,
    input  logic [4:0]                   req_rs2,
    input  logic [31:0]                  req_imm,
    output logic                         im_wr_en,
    output logic [31:0]                  im_addr,
    output logic [31:0]                  im_wdata,
    input  logic                         im_ready,
    output logic                         err,
    output logic [1:0]                   err_code,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic [1:0]                   dbg_state
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    localparam logic [3:0] CLS_R      = 4'd0;
    localparam logic [3:0] CLS_I      = 4'd1;
    localparam logic [3:0] CLS_LOAD   = 4'd2;
    localparam logic [3:0] CLS_STORE  = 4'd3;
    localparam logic [3:0] CLS_BRANCH = 4'd4;
    localparam logic [3:0] CLS_AUIPC  = 4'd5;
    localparam logic [3:0] CLS_LUI    = 4'd6;
    localparam logic [3:0] CLS_JAL    = 4'd7;
    localparam logic [3:0] CLS_JALR   = 4'd8;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t state, state_next;

    // ------------------------------------------------------------------
    // Combinational encoder
    // ------------------------------------------------------------------
    logic [2:0]  alu_f3;
    logic [6:0]  alu_f7;
    logic        alu_bad;
    logic        alu_shift;
    logic [2:0]  br_f3;
    logic        fits12, fits13, fits21;
    logic        bad_cls, bad_fn, bad_imm;
    logic [31:0] enc_word;
    logic [1:0]  enc_code;
    logic        enc_legal;

    // A value fits an N-bit signed field when all bits from N-1 upward match.
    assign fits12 = (req_imm[31:11] == '0) || (req_imm[31:11] == '1);
    assign fits13 = (req_imm[31:12] == '0) || (req_imm[31:12] == '1);
    assign fits21 = (req_imm[31:20] == '0) || (req_imm[31:20] == '1);

    always_comb begin
        alu_f3    = 3'd0;
        alu_f7    = 7'h00;
        alu_bad   = 1'b0;
        alu_shift = 1'b0;
        case (req_alu_op)
            4'd0: alu_f3 = 3'd0;                                  // ADD
            4'd1: begin alu_f3 = 3'd0; alu_f7 = 7'h20; end        // SUB
            4'd2: begin alu_f3 = 3'd1; alu_shift = 1'b1; end      // SLL
            4'd3: alu_f3 = 3'd2;                                  // SLT
            4'd4: alu_f3 = 3'd3;                                  // SLTU
            4'd5: alu_f3 = 3'd4;                                  // XOR
            4'd6: begin alu_f3 = 3'd5; alu_shift = 1'b1; end      // SRL
            4'd7: begin alu_f3 = 3'd5; alu_f7 = 7'h20; alu_shift = 1'b1; end // SRA
            4'd8: alu_f3 = 3'd6;                                  // OR
            4'd9: alu_f3 = 3'd7;                                  // AND
            default: alu_bad = 1'b1;
        endcase
    end

    always_comb begin
        br_f3 = 3'd0;
        case (req_br_type)
            3'd0: br_f3 = 3'd0;   // BEQ
            3'd1: br_f3 = 3'd1;   // BNE
            3'd2: br_f3 = 3'd4;   // BLT
            3'd3: br_f3 = 3'd5;   // BGE
            3'd4: br_f3 = 3'd6;   // BLTU
            3'd5: br_f3 = 3'd7;   // BGEU
            default: br_f3 = 3'd0;
        endcase
    end

    always_comb begin
        enc_word = 32'h0;
        bad_cls  = 1'b0;
        bad_fn   = 1'b0;
        bad_imm  = 1'b0;
        case (req_cls)
            CLS_R: begin
                bad_fn   = alu_bad;
                enc_word = {alu_f7, req_rs2, req_rs1, alu_f3, req_rd, OPC_R};
            end
            CLS_I: begin
                // There is no SUBI; subtract-immediate is ADDI with a negated imm.
                bad_fn = alu_bad || (req_alu_op == 4'd1);
                if (alu_shift) begin
                    bad_imm  = (req_imm[31:5] != '0);
                    enc_word = {alu_f7, req_imm[4:0], req_rs1, alu_f3, req_rd, OPC_I};
                end else begin
                    bad_imm  = !fits12;
                    enc_word = {req_imm[11:0], req_rs1, alu_f3, req_rd, OPC_I};
                end
            end
            CLS_LOAD: begin
                bad_fn   = (req_mem_f3 == 3'd3) || (req_mem_f3 > 3'd5);
                bad_imm  = !fits12;
                enc_word = {req_imm[11:0], req_rs1, req_mem_f3, req_rd, OPC_LOAD};
            end
            CLS_STORE: begin
                bad_fn   = (req_mem_f3 > 3'd2);
                bad_imm  = !fits12;
                enc_word = {req_imm[11:5], req_rs2, req_rs1, req_mem_f3,
                            req_imm[4:0], OPC_STORE};
            end
            CLS_BRANCH: begin
                bad_fn   = (req_br_type > 3'd5);
                bad_imm  = !fits13 || req_imm[0];
                enc_word = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, br_f3,
                            req_imm[4:1], req_imm[11], OPC_BRANCH};
            end
            CLS_AUIPC: begin
                bad_imm  = (req_imm[11:0] != 12'h000);
                enc_word = {req_imm[31:12], req_rd, OPC_AUIPC};
            end
            CLS_LUI: begin
                bad_imm  = (req_imm[11:0] != 12'h000);
                enc_word = {req_imm[31:12], req_rd, OPC_LUI};
            end
            CLS_JAL: begin
                bad_imm  = !fits21 || req_imm[0];
                enc_word = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12],
                            req_rd, OPC_JAL};
            end
            CLS_JALR: begin
                bad_imm  = !fits12;
                enc_word = {req_imm[11:0], req_rs1, 3'd0, req_rd, OPC_JALR};
            end
            default: bad_cls = 1'b1;
        endcase
    end

    // Class errors mask op/funct errors, which mask immediate errors.
    assign enc_code  = bad_cls ? 2'd1 : (bad_fn ? 2'd2 : (bad_imm ? 2'd3 : 2'd0));
    assign enc_legal = (enc_code == 2'd0);

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    logic          handshake;
    logic          write_done;
    logic [CW-1:0] count_inc;

    assign handshake  = req_valid && req_ready;
    assign write_done = (state == ST_WRITE) && im_wr_en && im_ready;
    assign count_inc  = count + ONE_C;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (handshake && enc_legal) begin
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (im_wr_en && im_ready) begin
                    state_next = (count_inc == DEPTH_C) ? ST_FULL : ST_IDLE;
                end
            end
            ST_FULL:  state_next = ST_FULL;
            default:  state_next = ST_IDLE;
        endcase
        if (clear) begin
            state_next = ST_IDLE;
        end
    end

    // Output logic
    always_comb begin
        req_ready = (state == ST_IDLE) && !clear;
        full      = (count == DEPTH_C);
        dbg_state = state;
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            im_wr_en <= 1'b0;
            im_addr  <= BASE_ADDR;
            im_wdata <= 32'h0;
            err      <= 1'b0;
            err_code <= 2'd0;
            count    <= '0;
        end else if (clear) begin
            // A write completing in this same cycle is deliberately dropped.
            im_wr_en <= 1'b0;
            im_addr  <= BASE_ADDR;
            err      <= 1'b0;
            count    <= '0;
        end else begin
            err <= 1'b0;
            if (handshake) begin
                if (enc_legal) begin
                    im_wr_en <= 1'b1;
                    im_wdata <= enc_word;
                end else begin
                    err      <= 1'b1;
                    err_code <= enc_code;
                end
            end
            if (write_done) begin
                im_wr_en <= 1'b0;
                im_addr  <= im_addr + 32'd4;
                count    <= count_inc;
            end
        end
    end

endmodule
